// File: rtl/hdlink_pkg.sv
// Shared types and constants for the half-duplex single-wire link responder.
package hdlink_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RX_START,
        RX_DATA,
        RX_PAR,
        RX_STOP,
        WAIT_HI,
        TURN,
        TX_START,
        TX_DATA,
        TX_PAR,
        TX_STOP
    } state_t;

    // Level of the released pad (external pull-up).
    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/hdlink_sync2.sv
// Two-flop synchronizer for the raw pad level; resets to the idle line level
// so that leaving reset never looks like a start-bit falling edge.
module hdlink_sync2
    import hdlink_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= LINE_IDLE;
            q    <= LINE_IDLE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bidir_link_responder.sv
// Responder end of a half-duplex single-wire UART-style link on one tri-state pin.
// Define HDLINK_PARITY_EN to add an even-parity bit after the data bits in both directions.
module bidir_link_responder
    import hdlink_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int DATA_W       = 8,
    parameter int TURN_CLKS    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pin_in,
    output logic              pin_oe,
    output logic              pin_out,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    input  logic [DATA_W-1:0] rsp_data,
    input  logic              rsp_valid,
    output logic              rsp_ready,
    output logic              busy
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_W + 1);
    localparam int TURN_W = (TURN_CLKS > 1) ? $clog2(TURN_CLKS) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN_CLKS - 1);

    state_t              state;
    state_t              state_next;
    logic                s_in;
    logic                s_prev;
    logic [BAUD_W-1:0]   baud_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [TURN_W-1:0]   turn_cnt;
    logic [DATA_W-1:0]   rx_shift;
    logic [DATA_W-1:0]   tx_shift;
    logic                baud_done;
    logic                half_done;
    logic                bit_last;
    logic                turn_last;
    logic                rx_ok;
    logic                rx_done_ok;
    logic                rx_done_bad;
`ifdef HDLINK_PARITY_EN
    logic                rx_par;
    logic                tx_par;
`endif

    hdlink_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (pin_in),
        .q   (s_in)
    );

    assign baud_done = (baud_cnt == BAUD_LAST);
    assign half_done = (baud_cnt == BAUD_HALF);
    assign bit_last  = (bit_cnt == BIT_LAST);
    assign turn_last = (turn_cnt == TURN_LAST);

`ifdef HDLINK_PARITY_EN
    assign rx_ok = (s_in == LINE_IDLE) && (rx_par == ^rx_shift);
`else
    assign rx_ok = (s_in == LINE_IDLE);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Response handshake: rsp_data is taken on the cycle where rsp_valid && rsp_ready.
    // rsp_ready is raised only in the last TURN cycle and only when rsp_valid is
    // already high, so it is a one-cycle acceptance pulse rather than a standing offer.
    always_comb begin
        state_next  = state;
        rsp_ready   = 1'b0;
        busy        = (state != IDLE);
        pin_oe      = 1'b0;
        pin_out     = 1'b0;
        rx_done_ok  = 1'b0;
        rx_done_bad = 1'b0;
        case (state)
            IDLE:     if (s_prev && !s_in) state_next = RX_START;
            RX_START: if (half_done) state_next = s_in ? IDLE : RX_DATA;
            RX_DATA: begin
                if (baud_done && bit_last) begin
`ifdef HDLINK_PARITY_EN
                    state_next = RX_PAR;
`else
                    state_next = RX_STOP;
`endif
                end
            end
            RX_PAR:   if (baud_done) state_next = RX_STOP;
            RX_STOP: begin
                if (baud_done) begin
                    if (rx_ok) begin
                        rx_done_ok = 1'b1;
                        state_next = TURN;
                    end else begin
                        rx_done_bad = 1'b1;
                        state_next  = WAIT_HI;
                    end
                end
            end
            WAIT_HI:  if (s_in == LINE_IDLE) state_next = IDLE;
            TURN: begin
                if (turn_last) begin
                    if (rsp_valid) begin
                        rsp_ready  = 1'b1;
                        state_next = TX_START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            TX_START: begin
                pin_oe  = 1'b1;
                pin_out = 1'b0;
                if (baud_done) state_next = TX_DATA;
            end
            TX_DATA: begin
                pin_oe  = 1'b1;
                pin_out = tx_shift[0];
                if (baud_done && bit_last) begin
`ifdef HDLINK_PARITY_EN
                    state_next = TX_PAR;
`else
                    state_next = TX_STOP;
`endif
                end
            end
            TX_PAR: begin
                pin_oe = 1'b1;
`ifdef HDLINK_PARITY_EN
                pin_out = tx_par;
`endif
                if (baud_done) state_next = TX_STOP;
            end
            TX_STOP: begin
                pin_oe  = 1'b1;
                pin_out = LINE_IDLE;
                if (baud_done) state_next = IDLE;
            end
            default:  state_next = IDLE;
        endcase
    end

    // Baud and bit counters restart on every state change so each state
    // measures its own bit time from its first cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_prev    <= LINE_IDLE;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            rx_data   <= '0;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            turn_cnt  <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
`ifdef HDLINK_PARITY_EN
            rx_par    <= 1'b0;
            tx_par    <= 1'b0;
`endif
        end else begin
            s_prev    <= s_in;
            rx_valid  <= rx_done_ok;
            frame_err <= rx_done_bad;
            if (rx_done_ok) rx_data <= rx_shift;

            if ((state_next != state) || baud_done) baud_cnt <= '0;
            else                                    baud_cnt <= baud_cnt + 1'b1;

            if (state_next != state)
                bit_cnt <= '0;
            else if (((state == RX_DATA) || (state == TX_DATA)) && baud_done)
                bit_cnt <= bit_cnt + 1'b1;

            if (state == TURN) turn_cnt <= turn_cnt + 1'b1;
            else               turn_cnt <= '0;

            if ((state == RX_DATA) && baud_done)
                rx_shift <= {s_in, rx_shift[DATA_W-1:1]};
`ifdef HDLINK_PARITY_EN
            if ((state == RX_PAR) && baud_done) rx_par <= s_in;
`endif

            if (rsp_ready) begin
                tx_shift <= rsp_data;
`ifdef HDLINK_PARITY_EN
                tx_par   <= ^rsp_data;
`endif
            end else if ((state == TX_DATA) && baud_done) begin
                tx_shift <= tx_shift >> 1;
            end
        end
    end

endmodule

// File: tb/tb_bidir_link_responder.sv
// Directed bench for bidir_link_responder: an initiator model shares the pad
// with the responder, and a negedge monitor records pulses and the TX waveform.
module tb_bidir_link_responder;

    localparam int CPB = 8;
    localparam int DW  = 8;
    localparam int TRN = 16;
`ifdef HDLINK_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int TX_CYCLES = FRAME_BITS * CPB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_line = 1'b1;
    logic          pin_in;
    logic          pin_oe;
    logic          pin_out;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic [DW-1:0] rsp_data = '0;
    logic          rsp_valid = 1'b0;
    logic          rsp_ready;
    logic          busy;
`ifdef HDLINK_PARITY_EN
    logic          par_flip = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    int            rxv_cnt = 0;
    int            fe_cnt = 0;
    int            rr_cnt = 0;
    int            oe_total = 0;
    int            oe_idx = 0;
    int            busy_total = 0;
    logic [DW-1:0] rx_capt = '0;
    logic          tx_bits [0:11];

    int b_rxv, b_fe, b_rr, b_oe, b_busy;

    // Released pad reads the initiator's drive (idle high through the pull-up).
    assign pin_in = pin_oe ? pin_out : init_line;

    bidir_link_responder #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (DW),
        .TURN_CLKS    (TRN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pin_in    (pin_in),
        .pin_oe    (pin_oe),
        .pin_out   (pin_out),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .rsp_data  (rsp_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pin_oe) begin
            if ((oe_idx % CPB == CPB / 2) && (oe_idx / CPB < 12))
                tx_bits[oe_idx / CPB] = pin_out;
            oe_idx++;
            oe_total++;
        end else begin
            oe_idx = 0;
        end
        if (rx_valid) begin
            rxv_cnt++;
            rx_capt = rx_data;
        end
        if (frame_err) fe_cnt++;
        if (rsp_ready) rr_cnt++;
        if (busy) busy_total++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_rxv  = rxv_cnt;
        b_fe   = fe_cnt;
        b_rr   = rr_cnt;
        b_oe   = oe_total;
        b_busy = busy_total;
    endtask

    task automatic drive_bit(input logic b);
        init_line = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic stop_b);
        drive_bit(1'b0);
        for (int i = 0; i < DW; i++) drive_bit(d[i]);
`ifdef HDLINK_PARITY_EN
        drive_bit((^d) ^ par_flip);
`endif
        drive_bit(stop_b);
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        int n;
        n = 0;
        while (busy && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(tag, busy, 1'b0);
    endtask

    task automatic wait_oe(input int max_cyc, input string tag);
        int n;
        n = 0;
        while (!pin_oe && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(tag, pin_oe, 1'b1);
    endtask

    logic exp_tx1 [0:FRAME_BITS-1];
`ifdef HDLINK_PARITY_EN
    logic exp_tx6 [0:FRAME_BITS-1];
`endif

    initial begin
`ifdef HDLINK_PARITY_EN
        exp_tx1 = '{1'b0, 1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0, 1'b1};
        exp_tx6 = '{1'b0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1, 1'b1};
`else
        exp_tx1 = '{1'b0, 1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,1'b0, 1'b1};
`endif

        // Reset state
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_pin_oe", pin_oe, 1'b0);
        check("rst_pin_out", pin_out, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_rsp_ready", rsp_ready, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: receive 0xA5, answer 0x3C
        rsp_data  = 8'h3C;
        rsp_valid = 1'b1;
        snap();
        send_frame(8'hA5, 1'b1);
        wait_idle(400, "t1_idle");
        check("t1_rxv_cnt", rxv_cnt - b_rxv, 1);
        check("t1_rx_capt", rx_capt, 8'hA5);
        check("t1_rx_data", rx_data, 8'hA5);
        check("t1_rr_cnt", rr_cnt - b_rr, 1);
        check("t1_fe_cnt", fe_cnt - b_fe, 0);
        check("t1_oe_cycles", oe_total - b_oe, TX_CYCLES);
        for (int i = 0; i < FRAME_BITS; i++)
            check($sformatf("t1_tx_bit%0d", i), tx_bits[i], exp_tx1[i]);
        check("t1_pin_oe_after", pin_oe, 1'b0);
        rsp_valid = 1'b0;
        repeat (10) @(negedge clk);

        // 2: receive 0x12 with no response pending
        snap();
        send_frame(8'h12, 1'b1);
        wait_idle(200, "t2_idle");
        check("t2_rxv_cnt", rxv_cnt - b_rxv, 1);
        check("t2_rx_data", rx_data, 8'h12);
        check("t2_rr_cnt", rr_cnt - b_rr, 0);
        check("t2_oe_cycles", oe_total - b_oe, 0);
        repeat (10) @(negedge clk);

        // 3: 0xFF with stop bit low, line then held low
        snap();
        send_frame(8'hFF, 1'b0);
        repeat (20) @(negedge clk);
        check("t3_fe_cnt", fe_cnt - b_fe, 1);
        check("t3_rxv_cnt", rxv_cnt - b_rxv, 0);
        check("t3_rx_data_held", rx_data, 8'h12);
        check("t3_busy_while_low", busy, 1'b1);
        init_line = 1'b1;
        wait_idle(10, "t3_idle_after_high");
        check("t3_oe_cycles", oe_total - b_oe, 0);
        repeat (10) @(negedge clk);

        // 4: 3-cycle glitch on an idle line
        snap();
        init_line = 1'b0;
        repeat (3) @(negedge clk);
        init_line = 1'b1;
        repeat (CPB) @(negedge clk);
        check("t4_busy_dropped", busy, 1'b0);
        check("t4_busy_seen", (busy_total - b_busy) > 0, 1'b1);
        check("t4_rxv_cnt", rxv_cnt - b_rxv, 0);
        check("t4_fe_cnt", fe_cnt - b_fe, 0);
        repeat (10) @(negedge clk);

        // 5: reset in the 4th bit of the response frame
        rsp_data  = 8'h3C;
        rsp_valid = 1'b1;
        send_frame(8'h5A, 1'b1);
        wait_oe(100, "t5_tx_started");
        repeat (3 * CPB + 3) @(negedge clk);
        check("t5_oe_before_rst", pin_oe, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_rst_pin_oe", pin_oe, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_rx_valid", rx_valid, 1'b0);
        check("t5_rst_frame_err", frame_err, 1'b0);
        check("t5_rst_rsp_ready", rsp_ready, 1'b0);
        check("t5_rst_rx_data", rx_data, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        rsp_valid = 1'b0;
        repeat (5) @(negedge clk);
        snap();
        send_frame(8'h69, 1'b1);
        wait_idle(200, "t5_idle");
        check("t5_rxv_cnt", rxv_cnt - b_rxv, 1);
        check("t5_rx_data", rx_data, 8'h69);
        check("t5_oe_cycles", oe_total - b_oe, 0);
        repeat (10) @(negedge clk);

`ifdef HDLINK_PARITY_EN
        // 6: wrong then correct parity on 0x01, response 0x07
        rsp_data  = 8'h07;
        rsp_valid = 1'b1;
        snap();
        par_flip = 1'b1;
        send_frame(8'h01, 1'b1);
        par_flip = 1'b0;
        repeat (40) @(negedge clk);
        check("t6_bad_fe_cnt", fe_cnt - b_fe, 1);
        check("t6_bad_rxv_cnt", rxv_cnt - b_rxv, 0);
        check("t6_bad_rr_cnt", rr_cnt - b_rr, 0);
        check("t6_bad_oe_cycles", oe_total - b_oe, 0);
        check("t6_bad_busy", busy, 1'b0);
        snap();
        send_frame(8'h01, 1'b1);
        wait_idle(400, "t6_idle");
        check("t6_rxv_cnt", rxv_cnt - b_rxv, 1);
        check("t6_rx_data", rx_data, 8'h01);
        check("t6_rr_cnt", rr_cnt - b_rr, 1);
        check("t6_oe_cycles", oe_total - b_oe, TX_CYCLES);
        for (int i = 0; i < FRAME_BITS; i++)
            check($sformatf("t6_tx_bit%0d", i), tx_bits[i], exp_tx6[i]);
        rsp_valid = 1'b0;
        repeat (10) @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
